bram_port_arbiter: RTL

Single-clock arbiter that lets NUM_CH requesters share one BRAM port. Typical requesters are the PS-side BRAM controller and the PL embed/extract engines. It replaces static mode-switched muxing with per-request valid/grant handshakes, registered BRAM commands and tagged read-data return. The block sits directly in front of BRAM port A in the steganography datapath.

---
 rtl/steg_bram_pkg.sv | 26 ++
 rtl/bram_arb_pick.sv | 34 +++
 rtl/bram_port_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/steg_bram_pkg.sv
// Shared constants for the steganography BRAM port: tag encoding, read-latency range, arbiter mode.
// No logic; the clog2 helper sizes the channel-index tag.
package steg_bram_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Valid bit carried alongside the channel index in the read-return pipeline
    localparam logic TAG_RD = 1'b1;
    localparam logic TAG_WR = 1'b0;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_arb_pick.sv
// Combinational one-hot picker: lowest index first, or round-robin starting after ptr.
// Zero latency; grants only asserted requesters, all-zero when none request.
module bram_arb_pick
    import steg_bram_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              mode,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   idx
);

    int   cand;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = (mode == ARB_RR) ? (int'(ptr) + 1 + k) % NUM_CH : k;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = CH_W'(cand);
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port among NUM_CH requesters; command 1 cycle after grant, read data RD_LATENCY+2 after.
// Requesters hold until granted; BRAM_ARB_RR_EN selects round-robin, otherwise fixed lowest-index priority.
module bram_port_arbiter
    import steg_bram_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTES  = DATA_WIDTH / 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                           pl_clk,
    input  logic                           pl_rst_n,
    input  logic [NUM_CH-1:0]              ch_req,
    output logic [NUM_CH-1:0]              ch_gnt,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_din,
    input  logic [NUM_CH*NUM_BYTES-1:0]    ch_we,
    output logic [DATA_WIDTH-1:0]          ch_rdata,
    output logic [NUM_CH-1:0]              ch_rvalid,
    output logic [ADDR_WIDTH-1:0]          bram_addr,
    output logic [DATA_WIDTH-1:0]          bram_din,
    input  logic [DATA_WIDTH-1:0]          bram_dout,
    output logic                           bram_en,
    output logic [NUM_BYTES-1:0]           bram_we,
    output logic                           bram_rst,
    output logic                           busy
);

    localparam int CH_W  = clog2(NUM_CH);
    // Out-of-range latencies are clamped so the tag pipeline always has at least two stages
    localparam int LAT   = (RD_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                           (RD_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : RD_LATENCY;
    localparam int DEPTH = LAT + 1;

    logic [NUM_CH-1:0]    pick_gnt;
    logic [CH_W-1:0]      pick_idx;
    logic [CH_W-1:0]      rr_ptr;
    logic                 mode;
    logic                 gnt_any;
    logic [NUM_BYTES-1:0] win_we;
    logic [DEPTH-1:0]     tag_vld;
    logic [CH_W-1:0]      tag_ch [DEPTH];

`ifdef BRAM_ARB_RR_EN
    assign mode = ARB_RR;

    // Reset value NUM_CH-1 makes the first search start at channel 0
    always_ff @(posedge pl_clk or negedge pl_rst_n) begin
        if (!pl_rst_n) begin
            rr_ptr <= CH_W'(NUM_CH - 1);
        end else if (gnt_any) begin
            rr_ptr <= pick_idx;
        end
    end
`else
    assign mode   = ARB_FIXED;
    assign rr_ptr = '0;
`endif

    bram_arb_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .req  (ch_req),
        .ptr  (rr_ptr),
        .mode (mode),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    assign ch_gnt   = pick_gnt;
    assign gnt_any  = |pick_gnt;
    assign win_we   = ch_we[int'(pick_idx)*NUM_BYTES +: NUM_BYTES];
    assign bram_rst = 1'b0;
    assign busy     = |tag_vld;

    always_ff @(posedge pl_clk or negedge pl_rst_n) begin
        if (!pl_rst_n) begin
            bram_addr <= '0;
            bram_din  <= '0;
            bram_en   <= 1'b0;
            bram_we   <= '0;
        end else if (gnt_any) begin
            bram_addr <= ch_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            bram_din  <= ch_din[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            bram_en   <= 1'b1;
            bram_we   <= win_we;
        end else begin
            bram_en   <= 1'b0;
            bram_we   <= '0;
        end
    end

    // One stage per cycle; the last stage lines up with bram_dout being valid
    always_ff @(posedge pl_clk or negedge pl_rst_n) begin
        if (!pl_rst_n) begin
            tag_vld <= '0;
            for (int i = 0; i < DEPTH; i++) tag_ch[i] <= '0;
        end else begin
            tag_vld   <= {tag_vld[DEPTH-2:0], (gnt_any && win_we == '0) ? TAG_RD : TAG_WR};
            tag_ch[0] <= pick_idx;
            for (int i = 1; i < DEPTH; i++) tag_ch[i] <= tag_ch[i-1];
        end
    end

    always_ff @(posedge pl_clk or negedge pl_rst_n) begin
        if (!pl_rst_n) begin
            ch_rvalid <= '0;
            ch_rdata  <= '0;
        end else begin
            ch_rvalid <= '0;
            if (tag_vld[DEPTH-1]) begin
                ch_rvalid[tag_ch[DEPTH-1]] <= 1'b1;
                ch_rdata                   <= bram_dout;
            end
        end
    end

endmodule
